// File: rtl/iter_divider.sv
// Multi-cycle restoring radix-2 divider for the EX-stage divide handshake.
// Produces {remainder, quotient} one quotient bit per cycle.
module iter_divider #(
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signed_div_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic                  start_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  ready_o
);

   localparam int CW = $clog2(DATA_W) + 1;

   typedef enum logic [1:0] {
      IDLE,
      BYZERO,
      ON,
      END
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [CW-1:0]       cnt;
   logic [2*DATA_W-1:0] work;
   logic [DATA_W-1:0]   dvsr;
   logic                sgn_r;
   logic                s1_r;
   logic                s2_r;
   logic                last;
   logic                go;
   logic [DATA_W:0]     trial;
   logic [DATA_W-1:0]   abs1;
   logic [DATA_W-1:0]   abs2;
   logic [DATA_W-1:0]   quo;
   logic [DATA_W-1:0]   rem;
   logic [DATA_W-1:0]   quo_fix;
   logic [DATA_W-1:0]   rem_fix;

   assign last  = (cnt == CW'(DATA_W));
   assign go    = start_i && !annul_i;
   assign abs1  = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
   assign abs2  = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
   // partial remainder carries one extra bit so the shifted value never overflows
   assign trial = work[2*DATA_W-1:DATA_W-1] - {1'b0, dvsr};
   assign quo   = work[DATA_W-1:0];
   assign rem   = work[2*DATA_W-1:DATA_W];
   assign quo_fix = (sgn_r && (s1_r ^ s2_r)) ? -quo : quo;
   assign rem_fix = (sgn_r && s1_r) ? -rem : rem;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next-state decode
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (go) state_nx = (opdata2_i == '0) ? BYZERO : ON;
         end
         BYZERO: state_nx = annul_i ? IDLE : END;
         ON: begin
            if (annul_i)   state_nx = IDLE;
            else if (last) state_nx = END;
         end
         END: begin
            if (!start_i) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // operand capture, iteration, sign fixup and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         work     <= '0;
         dvsr     <= '0;
         sgn_r    <= 1'b0;
         s1_r     <= 1'b0;
         s2_r     <= 1'b0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (go) begin
                  sgn_r <= signed_div_i;
                  s1_r  <= opdata1_i[DATA_W-1];
                  s2_r  <= opdata2_i[DATA_W-1];
                  work  <= {{DATA_W{1'b0}}, abs1};
                  dvsr  <= abs2;
                  cnt   <= '0;
               end
            end
            BYZERO: begin
               if (!annul_i) begin
                  result_o <= '0;
                  ready_o  <= 1'b1;
               end
            end
            ON: begin
               if (annul_i) begin
                  cnt <= '0;
               end else if (!last) begin
                  work <= {trial[DATA_W] ? work[2*DATA_W-2:DATA_W-1]
                                         : trial[DATA_W-1:0],
                           work[DATA_W-2:0], ~trial[DATA_W]};
                  cnt  <= cnt + 1'b1;
               end else begin
                  result_o <= {rem_fix, quo_fix};
                  ready_o  <= 1'b1;
                  cnt      <= '0;
               end
            end
            END: begin
               if (!start_i) begin
                  result_o <= '0;
                  ready_o  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard testbench for iter_divider.
// Expected results are queued at issue time and popped when ready_o rises.
module tb_iter_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int checks = 0;
   int failures = 0;
   logic [63:0] sb[$];

   iter_divider #(.DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic sd, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [31:0] q;
      logic [31:0] r;
      if (b == 32'd0) return 64'd0;
      if (!sd) begin
         q = a / b;
         r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end
      return {r, q};
   endfunction

   // drive a request on a falling edge and queue its expected result
   task automatic issue(input logic sd, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      signed_div_i = sd;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      sb.push_back(model(sd, a, b));
   endtask

   // count edges after the sampling edge until ready_o is seen high
   task automatic collect(output int lat, output logic [63:0] res, output bit to);
      @(posedge clk);
      lat = 0;
      to  = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (ready_o) begin
            to = 1'b0;
            break;
         end
      end
      res = result_o;
   endtask

   task automatic release_start();
      start_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      signed_div_i = 1'b0;
      opdata1_i = '0;
      opdata2_i = '0;
      start_i = 1'b0;
      annul_i = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (ready_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready got=%b want=0", ready_o);
      end
      checks++;
      if (result_o !== 64'd0) begin
         failures++;
         $display("FAIL reset_result got=%h want=0", result_o);
      end
      rst = 1'b0;
   endtask

   // run one division end to end with start held, then drop start
   task automatic run_one(input string nm, input logic sd,
                          input logic [31:0] a, input logic [31:0] b,
                          input int want_lat);
      int          lat;
      logic [63:0] res;
      logic [63:0] exp;
      bit          to;
      issue(sd, a, b);
      collect(lat, res, to);
      exp = sb.pop_front();
      checks++;
      if (to || lat != want_lat) begin
         failures++;
         $display("FAIL %s_latency got=%0d timeout=%0d want=%0d", nm, lat, to, want_lat);
      end
      checks++;
      if (res !== exp) begin
         failures++;
         $display("FAIL %s_result got=%h want=%h", nm, res, exp);
      end
      release_start();
      checks++;
      if (ready_o !== 1'b0 || result_o !== 64'd0) begin
         failures++;
         $display("FAIL %s_clear got=%b/%h want=0/0", nm, ready_o, result_o);
      end
   endtask

   task automatic test_unsigned();
      logic [63:0] exp;
      exp = {32'd2, 32'd14};
      checks++;
      if (model(1'b0, 32'd100, 32'd7) !== exp) begin
         failures++;
         $display("FAIL model_100_7 got=%h want=%h", model(1'b0, 32'd100, 32'd7), exp);
      end
      run_one("u100_7", 1'b0, 32'd100, 32'd7, 33);
      run_one("uffff_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33);
      run_one("u_big", 1'b0, 32'hDEAD_BEEF, 32'h0001_2345, 33);
   endtask

   task automatic test_signed();
      run_one("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33);
      run_one("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33);
      run_one("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33);
      run_one("s_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33);
      for (int i = 0; i < 4; i++) begin
         run_one("s_rand", 1'(i), $urandom, $urandom_range(1, 1000), 33);
      end
   endtask

   task automatic test_byzero();
      run_one("z_u", 1'b0, 32'd55, 32'd0, 1);
      run_one("z_s", 1'b1, 32'hFFFF_0000, 32'd0, 1);
   endtask

   task automatic test_annul();
      bit seen = 1'b0;
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i = 32'd1000;
      opdata2_i = 32'd3;
      start_i = 1'b1;
      repeat (11) @(negedge clk);
      annul_i = 1'b1;
      start_i = 1'b0;
      @(negedge clk);
      annul_i = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ready_o) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL annul_ready got=1 want=0");
      end
      @(negedge clk);
      start_i = 1'b1;
      annul_i = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (ready_o !== 1'b0) begin
         failures++;
         $display("FAIL annul_idle_block got=%b want=0", ready_o);
      end
      start_i = 1'b0;
      annul_i = 1'b0;
      run_one("after_annul", 1'b0, 32'd100, 32'd7, 33);
   endtask

   task automatic test_async_reset();
      int          lat;
      logic [63:0] res;
      bit          to;
      issue(1'b0, 32'd100, 32'd7);
      collect(lat, res, to);
      void'(sb.pop_front());
      #2 rst = 1'b1;
      #1;
      checks++;
      if (ready_o !== 1'b0 || result_o !== 64'd0) begin
         failures++;
         $display("FAIL async_rst_end got=%b/%h want=0/0", ready_o, result_o);
      end
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      issue(1'b1, 32'hFFFF_FFF9, 32'd2);
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (ready_o !== 1'b0 || result_o !== 64'd0) begin
         failures++;
         $display("FAIL async_rst_on got=%b/%h want=0/0", ready_o, result_o);
      end
      void'(sb.pop_front());
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      run_one("after_rst", 1'b1, 32'd7, 32'hFFFF_FFFE, 33);
   endtask

   task automatic test_operand_change();
      int          lat;
      logic [63:0] res;
      logic [63:0] exp;
      bit          to;
      issue(1'b0, 32'd100, 32'd7);
      @(posedge clk);
      @(negedge clk);
      opdata1_i = 32'd9;
      opdata2_i = 32'd0;
      signed_div_i = 1'b1;
      collect(lat, res, to);
      exp = sb.pop_front();
      checks++;
      if (to || res !== exp) begin
         failures++;
         $display("FAIL opchg_result got=%h timeout=%0d want=%h", res, to, exp);
      end
      release_start();
   endtask

   task automatic test_back_to_back();
      int          lat;
      logic [63:0] res;
      logic [63:0] exp;
      bit          to;
      issue(1'b0, 32'd1234, 32'd10);
      collect(lat, res, to);
      exp = sb.pop_front();
      repeat (4) @(negedge clk);
      checks++;
      if (to || ready_o !== 1'b1 || result_o !== exp) begin
         failures++;
         $display("FAIL hold_end got=%b/%h want=1/%h", ready_o, result_o, exp);
      end
      start_i = 1'b0;
      run_one("b2b", 1'b1, 32'hFFFF_FC00, 32'd7, 33);
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_byzero();
      test_annul();
      test_async_reset();
      test_operand_change();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle restoring radix-2 divider: the responder side of the EX-stage divide handshake (start/annul in, ready/result out).
- EX drives operands and start_i, holds start_i high while ready_o is low, and stalls the pipeline.
- The block latches the operands, iterates one quotient bit per cycle, then presents {remainder, quotient} with ready_o until EX drops start_i.

Parameters:
DATA_W, 32, operand width; result_o is 2*DATA_W bits

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-high
signed_div_i  input  1  1 = signed (two's complement) divide, 0 = unsigned
opdata1_i  input  DATA_W  dividend
opdata2_i  input  DATA_W  divisor
start_i  input  1  request; held high by EX until it samples ready_o high
annul_i  input  1  abort of the current operation
result_o  output  2*DATA_W  {remainder[2W-1:W], quotient[W-1:0]}; valid while ready_o=1
ready_o  output  1  result valid

Behaviour:
- Reset: asynchronous and active-high. Forces state to IDLE, ready_o=0, result_o=0, iteration counter=0 and internal registers=0. Reset mid-operation discards all work.
- States:
  - IDLE -> BYZERO if start_i & ~annul_i & opdata2_i==0.
  - IDLE -> ON if start_i & ~annul_i & opdata2_i!=0.
  - Otherwise stay in IDLE.
- Operand capture (edge leaving IDLE):
  - The signed flag, the absolute value of the dividend and the absolute value of the divisor are latched. Absolute values are taken only when signed_div_i=1; unsigned operands are latched as-is.
  - The sign of each original operand is also latched.
  - After capture, input changes are ignored until return to IDLE.
- ON: one restoring step per edge, counter 0..DATA_W-1.
  - Shift {rem, quo} left by 1, trial-subtract the divisor from the upper half.
  - If no borrow: keep the difference and set the quotient LSB to 1. Otherwise restore and set the LSB to 0.
  - After DATA_W iteration edges, the next edge performs sign fixup, enters END, registers result_o and sets ready_o=1.
- Latency: if edge 0 samples start, iterations occur on edges 1..DATA_W and ready_o is high after edge DATA_W+1 (edge 33 for DATA_W=32).
- Sign fixup (signed only):
  - Quotient is negated iff the operand signs differ.
  - Remainder is negated iff the dividend was negative.
  - Remainder sign always follows the dividend.
- Special cases:
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. This falls out of the unsigned magnitude arithmetic; no trap.
  - BYZERO: the next edge enters END with result_o=0 and ready_o=1 (ready high after edge 1). No exception is signalled.
- END: ready_o and result_o are held stable while start_i=1. The first edge with start_i=0 returns to IDLE and clears ready_o and result_o to 0. EX drops start_i combinationally on seeing ready_o, so ready_o is high for exactly one cycle in normal use.
- Annul:
  - annul_i=1 in ON or BYZERO -> IDLE on the next edge; ready_o stays 0 and the counter clears.
  - annul_i is ignored in END.
  - annul_i with start_i in IDLE prevents the start.
- Back-to-back: a new start_i is accepted only from IDLE, so the earliest restart is the cycle after END exits. A start_i held high through END, with no deassertion, keeps the block in END.
- All outputs come directly from registers; there is no combinational path from the inputs to ready_o or result_o.

Test Plan:
- Unsigned 100/7, start held → ready_o rises after edge 33. result_o = {32'd2, 32'd14}. Drop start → ready_o=0 and result_o=0 one edge later.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Signed 7/-2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Signed 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF/1 → quotient 0xFFFFFFFF, remainder 0.
- Divisor 0 (any dividend, either signedness) → ready_o=1 after edge 1, result_o=0. Check no ON cycles occur.
- annul_i pulsed at iteration 10 → state IDLE, ready_o never asserts. A following 100/7 start completes normally in 33 edges.
- rst asserted asynchronously mid-ON, between edges → ready_o=0 and result_o=0 immediately. A fresh start afterwards gives correct results.
- Operands changed during ON → the result reflects the captured operands.
